alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Upstream issue/writeback stage for the 8-bit combinational ALU.
- Accepts 16-bit register-register instructions over a valid/ready handshake and reads two operands from an internal 8x8 register file.
- Drives the ALU operand and opcode ports from registers, then writes RESULT into the destination register and captures the four flags into a status register.
- Also provides an external register-file write port (for loading constants) and a combinational debug read port.

Parameters:
- DATA_W, 8: operand/register width; must match the ALU width; only 8 is supported.
- NREGS, 8: register count; the instruction register fields are 3 bits wide.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- instr  input  16  instruction word: [15:12] OP, [11:9] RD, [8:6] RA, [5:3] RB, [2:0] reserved (ignored).
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  block can accept an instruction.
- ext_wr_en  input  1  external register write strobe.
- ext_wr_addr  input  3  external write register index.
- ext_wr_data  input  8  external write data.
- dbg_addr  input  3  debug read index.
- dbg_data  output  8  regs[dbg_addr], combinational.
- alu_a  output  8  registered operand A to the ALU.
- alu_b  output  8  registered operand B to the ALU.
- alu_op  output  4  registered OP_SEL to the ALU.
- alu_result  input  8  ALU RESULT.
- alu_c, alu_z, alu_v, alu_n  input  1 each  ALU CARRY, ZERO, OVERFLOW, NEGATIVE flags.
- flags  output  4  status register {C,Z,V,N}.
- done  output  1  one-cycle pulse after each writeback.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Interface fixed: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - All 8 registers = 0x00.
  - alu_a, alu_b = 0x00; alu_op = 0x0; flags = 0x0.
  - done = 0, busy = 0; instr_ready = 1 on the first cycle after reset.
- instr_ready = (state == IDLE); it is combinational from state and does not depend on instr_valid.
- FSM has three states: IDLE, READ, EXEC.
  - IDLE: if instr_valid, latch instr into the internal instruction register and go to READ; otherwise stay in IDLE.
  - READ: register alu_a = regs[RA], alu_b = regs[RB], alu_op = OP; go to EXEC.
  - EXEC: ALU outputs are sampled at the end of this cycle. On that edge: regs[RD] = alu_result, flags = {alu_c, alu_z, alu_v, alu_n}, done = 1 for the next cycle, go to IDLE.
- Timing: handshake in cycle N; regfile/flags updated at the end of N+2; done high and instr_ready high in N+3.
  - Throughput is one instruction per 3 cycles.
  - A new instruction may be accepted in the same cycle that done is high.
- alu_a, alu_b and alu_op hold their values after EXEC until the next READ.
- All 16 OP codes are forwarded unchanged, and every op writes RD (including compare ops). Flags are updated only in EXEC.
- RA == RB and RD equal to RA or RB are legal. Operands are the values sampled in READ.
- External write:
  - Accepted in any state; takes effect at the clock edge.
  - If it coincides with the EXEC writeback to the same index, the writeback wins. If the indices differ, both writes occur.
  - An external write in the READ cycle is not forwarded: READ sees the pre-edge value.
- dbg_data reflects the register contents after the last edge; it has no bypass.
- rst in any state aborts the operation with no writeback and returns all outputs to their reset values on the next cycle. Reset overrides a simultaneous ext_wr_en.
- instr_valid while not in IDLE is ignored; no instruction is latched.

Test Plan:
- Reset then idle: rst high 2 cycles, release -> instr_ready=1, busy=0, flags=0, dbg_data=0x00 for all 8 indices.
- Basic op:
  - Stimulus: ext write r1=0x12, r2=0x34; instr OP=0x5, RD=3, RA=1, RB=2 accepted in cycle N.
  - Cycle N+2: alu_a=0x12, alu_b=0x34, alu_op=0x5. Bench drives alu_result=0xAB, flags C=1 Z=0 V=1 N=1.
  - Required: cycle N+3 has done=1, regs[3]=0xAB, flags=4'b1011, instr_ready=1.
- Back-to-back: instr_valid held high with two instructions -> second accepted in the done cycle, 3 cycles after the first; the second's READ sees the first's RD result (r3 as RA gives alu_a=0xAB).
- Collision:
  - Same index: ext write r3=0x55 in the EXEC cycle of an instr with RD=3 -> regs[3]=alu_result.
  - Different index: ext write r4=0x55 in the same cycle -> regs[4]=0x55.
- Busy ignore: pulse instr_valid during READ/EXEC with a different instr -> no extra done, no register change.
- Reset mid-op: rst asserted in EXEC -> no write to RD, flags=0, state IDLE, done=0.

Source files
------------

// File: rtl/alu_issue.sv
// Issue/writeback stage for the 8-bit ALU: operand fetch from a small
// register file, registered ALU drive, result and flag writeback.
module alu_issue #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              ext_wr_en,
  input  logic [2:0]        ext_wr_addr,
  input  logic [DATA_W-1:0] ext_wr_data,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_c,
  input  logic              alu_z,
  input  logic              alu_v,
  input  logic              alu_n,
  output logic [3:0]        flags,
  output logic              done,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [12:0]       ir;
  logic [DATA_W-1:0] regs [NREGS];

  logic [3:0] ir_op;
  logic [2:0] ir_rd;
  logic [2:0] ir_ra;
  logic [2:0] ir_rb;
  logic       unused_bits;

  assign ir_op = ir[12:9];
  assign ir_rd = ir[8:6];
  assign ir_ra = ir[5:3];
  assign ir_rb = ir[2:0];

  // low three instruction bits are reserved
  assign unused_bits = ^instr[2:0];

  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign dbg_data    = regs[dbg_addr];

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (instr_valid) state_nxt = READ;
      READ: state_nxt = EXEC;
      EXEC: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ir     <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      flags  <= '0;
      done   <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == EXEC);
      if (state == IDLE && instr_valid) ir <= instr[15:3];
      if (state == READ) begin
        alu_a  <= regs[ir_ra];
        alu_b  <= regs[ir_rb];
        alu_op <= ir_op;
      end
      if (ext_wr_en) regs[ext_wr_addr] <= ext_wr_data;
      // writeback comes last so it beats an external write to the same index
      if (state == EXEC) begin
        regs[ir_rd] <= alu_result;
        flags       <= {alu_c, alu_z, alu_v, alu_n};
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: table-driven single ops plus
// back-to-back, collision, busy-ignore and mid-op reset sequences.
module tb_alu_issue;

  logic       clk = 1'b0;
  logic       rst;
  logic [15:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       ext_wr_en;
  logic [2:0] ext_wr_addr;
  logic [7:0] ext_wr_data;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_op;
  logic [7:0] alu_result;
  logic       alu_c, alu_z, alu_v, alu_n;
  logic [3:0] flags;
  logic       done;
  logic       busy;

  int checks = 0;
  int failures = 0;

  alu_issue dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .ext_wr_en   (ext_wr_en),
    .ext_wr_addr (ext_wr_addr),
    .ext_wr_data (ext_wr_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_c       (alu_c),
    .alu_z       (alu_z),
    .alu_v       (alu_v),
    .alu_n       (alu_n),
    .flags       (flags),
    .done        (done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [2:0] rd, ra, rb;
    logic [7:0] va, vb;
    logic [7:0] res;
    logic [3:0] fl;
    logic [7:0] ea, eb;
  } vec_t;

  vec_t vecs [4];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reg(input string nm, input logic [2:0] a,
                         input logic [7:0] exp);
    dbg_addr = a;
    #1;
    chk(nm, {24'd0, dbg_data}, {24'd0, exp});
  endtask

  task automatic ext_wr(input logic [2:0] a, input logic [7:0] d);
    ext_wr_en   = 1'b1;
    ext_wr_addr = a;
    ext_wr_data = d;
    tick;
    ext_wr_en   = 1'b0;
  endtask

  task automatic set_alu(input logic [7:0] r, input logic [3:0] f);
    alu_result = r;
    {alu_c, alu_z, alu_v, alu_n} = f;
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op,
    input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, rb, 3'b101};
  endfunction

  initial begin
    vecs[0] = '{4'h5, 3'd3, 3'd1, 3'd2, 8'h12, 8'h34,
                8'hAB, 4'b1011, 8'h12, 8'h34};
    vecs[1] = '{4'hF, 3'd0, 3'd7, 3'd7, 8'h80, 8'h81,
                8'h00, 4'b0100, 8'h81, 8'h81};
    vecs[2] = '{4'h0, 3'd5, 3'd5, 3'd6, 8'hFF, 8'h01,
                8'h00, 4'b1100, 8'hFF, 8'h01};
    vecs[3] = '{4'hA, 3'd2, 3'd4, 3'd6, 8'h7F, 8'h01,
                8'h80, 4'b0011, 8'h7F, 8'h01};

    rst = 1'b1;
    instr = '0;
    instr_valid = 1'b0;
    ext_wr_en = 1'b0;
    ext_wr_addr = '0;
    ext_wr_data = '0;
    dbg_addr = '0;
    set_alu(8'h00, 4'b0000);
    tick;
    tick;
    rst = 1'b0;
    #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", flags, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    for (int r = 0; r < 8; r++) chk_reg("rst_reg", 3'(r), 8'h00);

    // table-driven single instructions
    for (int i = 0; i < 4; i++) begin
      ext_wr(vecs[i].ra, vecs[i].va);
      ext_wr(vecs[i].rb, vecs[i].vb);
      instr = mk(vecs[i].op, vecs[i].rd, vecs[i].ra, vecs[i].rb);
      instr_valid = 1'b1;
      tick;
      instr_valid = 1'b0;
      chk("v_read_busy", busy, 1);
      chk("v_read_ready", instr_ready, 0);
      tick;
      chk("v_alu_a", alu_a, vecs[i].ea);
      chk("v_alu_b", alu_b, vecs[i].eb);
      chk("v_alu_op", alu_op, vecs[i].op);
      set_alu(vecs[i].res, vecs[i].fl);
      tick;
      chk("v_done", done, 1);
      chk("v_ready", instr_ready, 1);
      chk("v_flags", flags, vecs[i].fl);
      chk_reg("v_rd", vecs[i].rd, vecs[i].res);
      tick;
      chk("v_done_pulse", done, 0);
      chk("v_idle", busy, 0);
    end
    // r0=00 r1=12 r2=80 r3=AB r4=7F r5=00 r6=01 r7=81

    // back-to-back: second instr presented early, taken in the done cycle
    instr = mk(4'h1, 3'd4, 3'd3, 3'd2);
    instr_valid = 1'b1;
    tick;
    instr = mk(4'h2, 3'd5, 3'd4, 3'd3);
    tick;
    chk("b2b_alu_a", alu_a, 8'hAB);
    chk("b2b_alu_b", alu_b, 8'h80);
    chk("b2b_alu_op", alu_op, 4'h1);
    set_alu(8'h66, 4'b0001);
    tick;
    chk("b2b_done1", done, 1);
    chk("b2b_ready1", instr_ready, 1);
    chk("b2b_flags1", flags, 4'b0001);
    tick;
    instr_valid = 1'b0;
    chk("b2b_accept2", busy, 1);
    chk("b2b_done_low", done, 0);
    tick;
    chk("b2b_alu_a2", alu_a, 8'h66);
    chk("b2b_alu_b2", alu_b, 8'hAB);
    chk("b2b_alu_op2", alu_op, 4'h2);
    // same-index collision: writeback beats external write
    set_alu(8'h77, 4'b1000);
    ext_wr(3'd5, 8'h55);
    chk("b2b_done2", done, 1);
    chk("b2b_flags2", flags, 4'b1000);
    chk_reg("coll_same", 3'd5, 8'h77);
    tick;

    // different-index collision, busy ignore, READ-cycle ext write
    instr = mk(4'h3, 3'd6, 3'd0, 3'd1);
    instr_valid = 1'b1;
    tick;
    instr = mk(4'hF, 3'd7, 3'd7, 3'd7);
    ext_wr(3'd1, 8'h3C);
    instr_valid = 1'b0;
    chk("ign_alu_a", alu_a, 8'h00);
    chk("ign_alu_b_nofwd", alu_b, 8'h12);
    chk("ign_alu_op", alu_op, 4'h3);
    instr_valid = 1'b1;
    set_alu(8'h99, 4'b0010);
    ext_wr(3'd4, 8'h55);
    instr_valid = 1'b0;
    chk("diff_done", done, 1);
    chk_reg("diff_rd", 3'd6, 8'h99);
    chk_reg("diff_ext", 3'd4, 8'h55);
    chk_reg("read_ext", 3'd1, 8'h3C);
    tick;
    chk("ign_no_done", done, 0);
    chk("ign_idle", busy, 0);
    tick;
    chk("ign_still_idle", busy, 0);
    chk_reg("ign_r7", 3'd7, 8'h81);

    // reset during EXEC aborts writeback and beats ext write
    instr = mk(4'h7, 3'd1, 3'd1, 3'd1);
    instr_valid = 1'b1;
    tick;
    instr_valid = 1'b0;
    tick;
    chk("rmid_alu_a", alu_a, 8'h3C);
    rst = 1'b1;
    set_alu(8'hEE, 4'b1111);
    ext_wr(3'd2, 8'hAA);
    rst = 1'b0;
    chk("rmid_done", done, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_ready", instr_ready, 1);
    chk("rmid_flags", flags, 0);
    chk("rmid_alu_a0", alu_a, 0);
    chk_reg("rmid_rd", 3'd1, 8'h00);
    chk_reg("rmid_ext", 3'd2, 8'h00);
    tick;
    chk("rmid_no_done", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
